// File: rtl/shift_src_reg.sv
//------------------------------------------------------------------------------
// shift_src_reg
//
// Purpose:
//   8-bit sequential source register for the combinational barrel shifter.
//   Each command applies one single-bit shift, load or LFSR operation per
//   clock, rep+1 times. A registered one-cycle done pulse marks the cycle in
//   which dout is final.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous reset, active-low
//   en     in   1  command start, sampled only while idle
//   op     in   3  operation code, captured at start
//   rep    in   3  extra repetitions (ignored for clear/load)
//   din    in   8  parallel load value, captured at start
//   sin    in   1  serial input for op 110, sampled live on every step
//   dout   out  8  register contents (barrel-shifter din)
//   busy   out  1  high while a multi-step command is running
//   done   out  1  one-cycle pulse after the final step
//
// Build option:
//   SHREG_LFSR_EN  defined   : op 111 is an 8-bit LFSR step with 00 escape
//                  undefined : op 111 holds dout (counting/busy/done unchanged)
//
// States:
//   state  | meaning
//   S_IDLE | waiting for en; start edge applies step 1
//   S_RUN  | applying remaining steps, r_cnt steps left
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module shift_src_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] op,
    input  logic [2:0] rep,
    input  logic [7:0] din,
    input  logic       sin,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSR  = 3'b010;
    localparam logic [2:0] OP_LSL  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_SER  = 3'b110;
    localparam logic [2:0] OP_LFSR = 3'b111;

    state_t     r_state;
    logic [2:0] r_op;
    logic [2:0] r_cnt;
    logic [7:0] r_din;
    logic [7:0] r_dout;
    logic       r_busy;
    logic       r_done;

    logic [2:0] w_op;
    logic [7:0] w_ld;
    logic       w_single;
    logic [2:0] w_rep_eff;
    logic       w_lfsr_fb;
    logic [7:0] w_next;

    // The start edge already applies step 1, so while idle the step logic
    // works from the live inputs rather than the captured copies.
    always_comb begin
        w_op      = (r_state == S_IDLE) ? op  : r_op;
        w_ld      = (r_state == S_IDLE) ? din : r_din;
        w_single  = (op == OP_CLR) || (op == OP_LOAD);
        w_rep_eff = w_single ? 3'd0 : rep;
        w_lfsr_fb = r_dout[4] ^ r_dout[3] ^ r_dout[2] ^ r_dout[0];
        w_next    = r_dout;
        case (w_op)
            OP_CLR:  w_next = 8'h00;
            OP_LOAD: w_next = w_ld;
            OP_LSR:  w_next = {1'b0, r_dout[7:1]};
            OP_LSL:  w_next = {r_dout[6:0], 1'b0};
            OP_ASR:  w_next = {r_dout[7], r_dout[7:1]};
            OP_ROR:  w_next = {r_dout[0], r_dout[7:1]};
            OP_SER:  w_next = {sin, r_dout[7:1]};
            OP_LFSR: begin
`ifdef SHREG_LFSR_EN
                // All-zero is the LFSR lock-up state; reseed with 01.
                if (r_dout == 8'h00) begin
                    w_next = 8'h01;
                end else begin
                    w_next = {w_lfsr_fb, r_dout[7:1]};
                end
`else
                w_next = r_dout;
`endif
            end
            default: w_next = r_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 3'd0;
            r_cnt   <= 3'd0;
            r_din   <= 8'h00;
            r_dout  <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_op   <= op;
                        r_din  <= din;
                        r_dout <= w_next;
                        if (w_rep_eff == 3'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt   <= w_rep_eff;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // en is deliberately not looked at here: no queuing.
                    r_dout <= w_next;
                    r_cnt  <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign dout = r_dout;
    assign busy = r_busy;
    assign done = r_done;

endmodule
